// File: rtl/clk_div_pkg.sv
// clk_div_pkg: output mode type, default parameters and channel-index width helper
package clk_div_pkg;
  typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} mode_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_RST_DIV = 50000000;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; new divisors wait in a shadow until the next terminal count
module clk_div_chan import clk_div_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  input  logic             wr_en,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt, div, shadow, last;
  mode_t mode;
  logic en, term, clr, direct;
  always_comb begin
    last = (div == '0) ? '0 : div - CNT_W'(1);
    term = en && cnt >= last;
    clr = wr && (mode_t'(wr_mode) != mode || !wr_en);
    direct = !(wr_en && en);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      div <= CNT_W'(RST_DIV);
      shadow <= CNT_W'(RST_DIV);
      mode <= MODE_TOGGLE;
      en <= 1'b1;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
      pending <= 1'b0;
      div <= wr ? wr_div : (pending ? shadow : div);
      if (wr) begin
        shadow <= wr_div;
        mode <= mode_t'(wr_mode);
        en <= wr_en;
      end
    end else begin
      if (wr) begin
        shadow <= wr_div;
        mode <= mode_t'(wr_mode);
        en <= wr_en;
        pending <= !direct;
        if (direct) div <= wr_div;
      end else if (pending && term) begin
        div <= shadow;
        pending <= 1'b0;
      end
      // a mode change or disable starts the channel over from a low, idle output
      if (clr) begin
        cnt <= '0;
        clk_out <= 1'b0;
        tick <= 1'b0;
      end else if (en) begin
        cnt <= term ? '0 : cnt + CNT_W'(1);
        tick <= term;
        clk_out <= (mode == MODE_PULSE) ? term : clk_out ^ term;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: bank of programmable clock dividers with a shared configuration port
module clk_div_multi import clk_div_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int RST_DIV = DEF_RST_DIV,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);
  logic [NUM_CH-1:0] pending, wr;
  logic accept, hit;
  always_comb begin
    cfg_ready = ~|pending;
    accept = cfg_valid && cfg_ready;
    hit = int'(cfg_ch) < NUM_CH;
  end
  always_ff @(posedge clk) begin
    cfg_err <= !reset && accept && !hit;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = accept && hit && cfg_ch == CH_W'(i);
    clk_div_chan #(.CNT_W(CNT_W), .RST_DIV(RST_DIV)) u_chan (
      .clk(clk),
      .reset(reset),
      .restart(sync_restart),
      .wr(wr[i]),
      .wr_div(cfg_div),
      .wr_mode(cfg_mode),
      .wr_en(cfg_en),
      .pending(pending[i]),
      .clk_out(clk_out[i]),
      .tick(tick[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: 4- and 3-channel instances driven in parallel, checked every cycle against a tick-schedule model
module tb_clk_div_multi;
  localparam int RST = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_mode = 1'b0;
  logic cfg_en = 1'b1;
  logic sync_restart = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic a_ready, b_ready, a_err, b_err;
  logic [3:0] a_clk, a_tick;
  logic [2:0] b_clk, b_tick;

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(4), .CNT_W(8), .RST_DIV(RST)) dut_a (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(a_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en), .sync_restart(sync_restart),
    .clk_out(a_clk), .tick(a_tick), .cfg_err(a_err));

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .RST_DIV(RST)) dut_b (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(b_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en), .sync_restart(sync_restart),
    .clk_out(b_clk), .tick(b_tick), .cfg_err(b_err));

  // per channel: the cycle number at which the next tick is due, plus config state
  typedef struct {
    bit en;
    bit mode;
    int per;
    int shadow;
    bit pend;
    int nt;
    bit lvl;
    bit tk;
  } ch_t;
  ch_t m [2][4];
  bit m_err [2];
  bit acc [2];
  int nch [2] = '{4, 3};
  int t = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int eff(int x);
    return x == 0 ? 1 : x;
  endfunction

  function automatic bit exp_rdy(int d);
    bit r = 1'b1;
    for (int c = 0; c < nch[d]; c++) if (m[d][c].pend) r = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_clk(int d);
    logic [3:0] v = '0;
    for (int c = 0; c < nch[d]; c++) v[c] = m[d][c].mode ? m[d][c].tk : m[d][c].lvl;
    return v;
  endfunction

  function automatic logic [3:0] exp_tick(int d);
    logic [3:0] v = '0;
    for (int c = 0; c < nch[d]; c++) v[c] = m[d][c].tk;
    return v;
  endfunction

  task automatic step();
    t++;
    for (int d = 0; d < 2; d++) begin
      bit hit;
      acc[d] = !reset && cfg_valid && exp_rdy(d);
      hit = acc[d] && int'(cfg_ch) < nch[d];
      m_err[d] = acc[d] && !hit;
      for (int c = 0; c < nch[d]; c++) begin
        ch_t s = m[d][c];
        bit w = hit && int'(cfg_ch) == c;
        if (reset) begin
          s.en = 1; s.mode = 0; s.per = RST; s.shadow = RST; s.pend = 0;
          s.nt = t + RST; s.lvl = 0; s.tk = 0;
        end else if (sync_restart) begin
          if (s.pend) s.per = s.shadow;
          s.pend = 0;
          if (w) begin
            s.per = int'(cfg_div); s.shadow = int'(cfg_div); s.mode = cfg_mode; s.en = cfg_en;
          end
          s.nt = t + eff(s.per); s.lvl = 0; s.tk = 0;
        end else begin
          s.tk = s.en && s.nt == t;
          if (s.tk) begin
            if (s.pend) s.per = s.shadow;
            s.pend = 0;
            s.nt = t + eff(s.per);
            s.lvl = !s.lvl;
          end
          if (w) begin
            bit was = s.en;
            bit chg = cfg_mode != s.mode;
            s.mode = cfg_mode; s.en = cfg_en; s.shadow = int'(cfg_div);
            if (was && cfg_en) s.pend = 1;
            else s.per = int'(cfg_div);
            if (!cfg_en || chg || !was) begin
              s.nt = t + eff(s.per); s.lvl = 0; s.tk = 0;
            end
          end
        end
        m[d][c] = s;
      end
    end
  endtask

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d got=%b expected=%b", tag, t, got, exp);
    end
  endtask

  task automatic check();
    chk("a_clk_out", a_clk, exp_clk(0));
    chk("a_tick", a_tick, exp_tick(0));
    chk("a_cfg_ready", {3'b0, a_ready}, {3'b0, exp_rdy(0)});
    chk("a_cfg_err", {3'b0, a_err}, {3'b0, m_err[0]});
    chk("b_clk_out", {1'b0, b_clk}, exp_clk(1));
    chk("b_tick", {1'b0, b_tick}, exp_tick(1));
    chk("b_cfg_ready", {3'b0, b_ready}, {3'b0, exp_rdy(1)});
    chk("b_cfg_err", {3'b0, b_err}, {3'b0, m_err[1]});
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    check();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(int ch, int dv, bit md, bit e, bit rs);
    int k = 0;
    while (!exp_rdy(0) && k < 300) begin cyc(); k++; end
    cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_mode = md; cfg_en = e; sync_restart = rs; cfg_valid = 1'b1;
    k = 0;
    do begin cyc(); k++; end while (!acc[0] && k < 300);
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
    n_cmp++;
    assert (acc[0] === 1'b1) else begin
      n_bad++;
      $error("FAIL wr_accept ch=%0d got=none expected=accepted", ch);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    run(2);
    chk("rst_clk_out", a_clk, 4'b0000);
    chk("rst_ready", {3'b0, a_ready}, 4'b0001);
    reset = 1'b0;
    run(14);
    wr(1, 5, 1'b1, 1'b1, 1'b0);
    chk("pend_ready_low", {3'b0, a_ready}, 4'b0000);
    run(15);
    wr(0, 10, 1'b0, 1'b1, 1'b0);
    k = 0;
    while ((m[0][0].pend || m[0][0].nt - t != 9) && k < 100) begin cyc(); k++; end
    wr(0, 2, 1'b0, 1'b1, 1'b0);
    run(30);
    wr(0, 4, 1'b0, 1'b1, 1'b0);
    wr(1, 5, 1'b1, 1'b1, 1'b0);
    wr(2, 6, 1'b0, 1'b1, 1'b0);
    wr(3, 7, 1'b1, 1'b1, 1'b1);
    chk("restart_clk_out", a_clk, 4'b0000);
    run(30);
    wr(3, 2, 1'b0, 1'b1, 1'b0);
    chk("b_err_pulse", {3'b0, b_err}, 4'b0001);
    run(6);
    wr(2, 0, 1'b0, 1'b1, 1'b0);
    run(10);
    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(3) == 0);
      cfg_ch = 2'($urandom_range(3));
      cfg_div = 8'($urandom_range(9));
      cfg_mode = 1'($urandom_range(1));
      cfg_en = ($urandom_range(5) != 0);
      sync_restart = ($urandom_range(19) == 0);
      reset = ($urandom_range(99) == 0);
      cyc();
    end
    reset = 1'b0; sync_restart = 1'b0; cfg_valid = 1'b0; cfg_en = 1'b1;
    run(7);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9; cfg_mode = 1'b1; sync_restart = 1'b1; reset = 1'b1;
    cyc();
    chk("midrst_clk_out", a_clk, 4'b0000);
    chk("midrst_tick", a_tick, 4'b0000);
    reset = 1'b0; cfg_valid = 1'b0; sync_restart = 1'b0;
    run(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
